// File: rtl/video_timing_pkg.sv
// video_timing_pkg: SVGA 800x600@60 timing constants, counter type and window helper.
package video_timing_pkg;
    localparam int CNT_W = 11;
    typedef logic [CNT_W-1:0] cnt_t;
    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
        logic sof;
    } flags_t;
    localparam int SVGA_H_ACTIVE = 800;
    localparam int SVGA_H_FP = 40;
    localparam int SVGA_H_SYNC = 128;
    localparam int SVGA_H_BP = 88;
    localparam int SVGA_V_ACTIVE = 600;
    localparam int SVGA_V_FP = 1;
    localparam int SVGA_V_SYNC = 4;
    localparam int SVGA_V_BP = 23;
    localparam logic HS_POL_DEF = 1'b1;
    localparam logic VS_POL_DEF = 1'b1;
    function automatic logic in_window(input cnt_t c, input int lo, input int hi);
        return c >= cnt_t'(lo) && c < cnt_t'(hi);
    endfunction
endpackage

// File: rtl/video_timing_generator_wrap_counter.sv
// wrap_counter: enabled up-counter wrapping at TOTAL-1, with a same-cycle wrap pulse.
module wrap_counter
    import video_timing_pkg::*;
#(
    parameter int TOTAL = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output cnt_t cnt_o,
    output logic wrap_o
);
    cnt_t cnt_q, cnt_d;
    assign wrap_o = en_i && cnt_q == cnt_t'(TOTAL - 1);
    assign cnt_o = cnt_q;
    always_comb cnt_d = !en_i ? cnt_q : wrap_o ? '0 : cnt_q + cnt_t'(1);
    always_ff @(posedge clk_i) cnt_q <= rst_i ? '0 : cnt_d;
endmodule

// File: rtl/video_timing_generator.sv
// video_timing_generator: raster counters with registered de/hs/vs/sof/x/y decodes.
module video_timing_generator
    import video_timing_pkg::*;
#(
    parameter int   H_ACTIVE = SVGA_H_ACTIVE,
    parameter int   H_FP     = SVGA_H_FP,
    parameter int   H_SYNC   = SVGA_H_SYNC,
    parameter int   H_BP     = SVGA_H_BP,
    parameter int   V_ACTIVE = SVGA_V_ACTIVE,
    parameter int   V_FP     = SVGA_V_FP,
    parameter int   V_SYNC   = SVGA_V_SYNC,
    parameter int   V_BP     = SVGA_V_BP,
    parameter logic HS_POL   = HS_POL_DEF,
    parameter logic VS_POL   = VS_POL_DEF
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_en,
    output logic        o_de,
    output logic        o_hs,
    output logic        o_vs,
    output logic [10:0] o_x,
    output logic [10:0] o_y,
    output logic        o_sof
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    cnt_t h_cnt, v_cnt, x_q, y_q;
    logic h_wrap, v_wrap, origin_q;
    flags_t flags_d, flags_q;
    wrap_counter #(.TOTAL(H_TOTAL)) u_h (
        .clk_i(i_clk), .rst_i(i_rst), .en_i(i_en), .cnt_o(h_cnt), .wrap_o(h_wrap)
    );
    wrap_counter #(.TOTAL(V_TOTAL)) u_v (
        .clk_i(i_clk), .rst_i(i_rst), .en_i(h_wrap), .cnt_o(v_cnt), .wrap_o(v_wrap)
    );
    // origin_q marks that the counters sit at (0,0): set by reset and by the frame wrap.
    always_comb begin
        flags_d.de  = in_window(h_cnt, 0, H_ACTIVE) && in_window(v_cnt, 0, V_ACTIVE);
        flags_d.hs  = in_window(h_cnt, H_ACTIVE + H_FP, H_ACTIVE + H_FP + H_SYNC) ? HS_POL : ~HS_POL;
        flags_d.vs  = in_window(v_cnt, V_ACTIVE + V_FP, V_ACTIVE + V_FP + V_SYNC) ? VS_POL : ~VS_POL;
        flags_d.sof = origin_q;
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            flags_q  <= '{de: 1'b0, hs: ~HS_POL, vs: ~VS_POL, sof: 1'b0};
            x_q      <= '0;
            y_q      <= '0;
            origin_q <= 1'b1;
        end else if (i_en) begin
            flags_q  <= flags_d;
            x_q      <= h_cnt;
            y_q      <= v_cnt;
            origin_q <= v_wrap;
        end else begin
            flags_q.sof <= 1'b0;
        end
    end
    assign o_de  = flags_q.de;
    assign o_hs  = flags_q.hs;
    assign o_vs  = flags_q.vs;
    assign o_sof = flags_q.sof;
    assign o_x   = x_q;
    assign o_y   = y_q;
endmodule

// File: tb/tb_video_timing_generator.sv
// tb_video_timing_generator: directed checks on an SVGA instance and a small inverted-polarity instance.
module tb_video_timing_generator;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_a, en_a, rst_b, en_b;
    logic de_a, hs_a, vs_a, sof_a, de_b, hs_b, vs_b, sof_b;
    logic [10:0] x_a, y_a, x_b, y_b;
    int checks = 0, failures = 0;
    int de_n, sof_n, hs_n, vs_n, hs_first, hs_last, rise2, n, ex, ey;
    logic hs_prev;
    logic [31:0] exp_vec;

    video_timing_generator u_a (
        .i_clk(clk), .i_rst(rst_a), .i_en(en_a), .o_de(de_a), .o_hs(hs_a), .o_vs(vs_a),
        .o_x(x_a), .o_y(y_a), .o_sof(sof_a)
    );
    video_timing_generator #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) u_b (
        .i_clk(clk), .i_rst(rst_b), .i_en(en_b), .o_de(de_b), .o_hs(hs_b), .o_vs(vs_b),
        .o_x(x_b), .o_y(y_b), .o_sof(sof_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_a = 1; en_a = 1; rst_b = 1; en_b = 1;
        repeat (3) tick;
        chk("rst_de", de_a, 0); chk("rst_sof", sof_a, 0); chk("rst_x", x_a, 0);
        chk("rst_y", y_a, 0); chk("rst_hs", hs_a, 0); chk("rst_vs", vs_a, 0);
        chk("rstb_hs", hs_b, 1); chk("rstb_vs", vs_b, 1); chk("rstb_de", de_b, 0);
        rst_a = 0;
        de_n = 0; sof_n = 0; hs_n = 0; vs_n = 0; hs_first = -1; hs_last = -1; rise2 = -1; hs_prev = 0;
        for (int i = 0; i < 2112; i++) begin
            tick;
            chk("sweep_x", x_a, i % 1056);
            chk("sweep_y", y_a, i / 1056);
            if (i == 0) begin
                chk("first_de", de_a, 1);
                chk("first_sof", sof_a, 1);
            end
            if (i == 800) chk("de_off_800", de_a, 0);
            if (i < 1056) begin
                de_n += int'(de_a);
                sof_n += int'(sof_a);
                vs_n += int'(vs_a);
                if (hs_a) begin
                    hs_n++;
                    if (hs_first < 0) hs_first = i;
                    hs_last = i;
                end
            end else if (hs_a && !hs_prev && rise2 < 0) rise2 = i;
            hs_prev = hs_a;
        end
        chk("de_count", de_n, 800); chk("sof_count", sof_n, 1); chk("vs_line0", vs_n, 0);
        chk("hs_count", hs_n, 128); chk("hs_first", hs_first, 840); chk("hs_last", hs_last, 967);
        chk("hs_rise2", rise2, 1896);
        repeat (501) tick;
        chk("pause_x", x_a, 500); chk("pause_y", y_a, 2);
        en_a = 0;
        repeat (10) begin
            tick;
            chk("hold_x", x_a, 500); chk("hold_de", de_a, 1); chk("hold_sof", sof_a, 0); chk("hold_hs", hs_a, 0);
        end
        en_a = 1;
        tick;
        chk("resume_x", x_a, 501);
        n = 0;
        while (x_a != 0 && n < 2000) begin
            tick;
            n++;
        end
        chk("late_line_len", n, 555); chk("late_line_y", y_a, 3);
        rst_a = 1;
        tick;
        chk("mid_rst_x", x_a, 0); chk("mid_rst_y", y_a, 0); chk("mid_rst_de", de_a, 0);
        chk("mid_rst_sof", sof_a, 0); chk("mid_rst_hs", hs_a, 0);
        rst_a = 0;
        tick;
        chk("restart_sof", sof_a, 1); chk("restart_de", de_a, 1); chk("restart_x", x_a, 0);
        tick;
        chk("restart_sof_off", sof_a, 0); chk("restart_x1", x_a, 1);
        rst_b = 0;
        for (int k = 0; k < 300; k++) begin
            tick;
            ex = k % 16;
            ey = (k / 16) % 9;
            exp_vec = {6'd0, ex < 8 && ey < 4, !(ex >= 10 && ex < 13), !(ey >= 5 && ey < 7),
                       k % 144 == 0, 11'(ex), 11'(ey)};
            chk("small_vec", {6'd0, de_b, hs_b, vs_b, sof_b, x_b, y_b}, exp_vec);
        end
        repeat (80) tick;
        chk("sync_x", x_b, 11); chk("sync_y", y_b, 5); chk("sync_hs", hs_b, 0); chk("sync_vs", vs_b, 0);
        rst_b = 1;
        tick;
        chk("sync_rst_x", x_b, 0); chk("sync_rst_y", y_b, 0); chk("sync_rst_hs", hs_b, 1);
        chk("sync_rst_vs", vs_b, 1); chk("sync_rst_de", de_b, 0); chk("sync_rst_sof", sof_b, 0);
        rst_b = 0;
        tick;
        chk("b_restart_sof", sof_b, 1); chk("b_restart_de", de_b, 1); chk("b_restart_hs", hs_b, 1);
        chk("b_restart_vs", vs_b, 1); chk("b_restart_x", x_b, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
